ppe_row_sync: RTL and testbench

- Clocked, parametrised successor to the CSP partial-product element.
- Accepts 33-bit NoC packets: weight packets carry a filter row, input packets carry one ifmap row of binary spikes.
- For each input row, emits one partial-sum packet per valid 1-D convolution window to a summation element (SPE).
- Sits between the NoC router output port and the SPE input, using ready/valid handshakes.

---
 rtl/ppe_pkg.sv | 29 ++
 rtl/ppe_window_mac.sv | 24 ++
 rtl/ppe_row_sync.sv | 164 ++++++++++++++++
 tb/tb_ppe_row_sync.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppe_pkg.sv
// Shared packet layout, opcodes and FSM state type for the partial-product element.
package ppe_pkg;

    localparam int ADDR_START   = 32;
    localparam int ADDR_END     = 29;
    localparam int OPCODE_START = 28;
    localparam int OPCODE_END   = 25;
    localparam int DATA_START   = 24;
    localparam int DATA_END     = 0;

    // Bit position of the window index inside the partial-sum data field.
    localparam int J_POS = 16;

    localparam logic [OPCODE_START-OPCODE_END:0] OP_WEIGHT = 4'd0;
    localparam logic [OPCODE_START-OPCODE_END:0] OP_INPUT  = 4'd1;
    localparam logic [OPCODE_START-OPCODE_END:0] OP_PSUM   = 4'd2;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    typedef struct packed {
        logic [ADDR_START-ADDR_END:0]     addr;
        logic [OPCODE_START-OPCODE_END:0] opcode;
        logic [DATA_START-DATA_END:0]     data;
    } packet_t;

endpackage

// File: rtl/ppe_window_mac.sv
// Combinational dot product of one binary spike window with the filter weight row.
module ppe_window_mac
    import ppe_pkg::*;
#(
    parameter int FILTER_W = 5,
    parameter int WEIGHT_W = 8,
    parameter int PSUM_W   = 11
) (
    input  logic [FILTER_W-1:0]               i_spikes,
    input  logic [FILTER_W-1:0][WEIGHT_W-1:0] i_weights,
    output logic [PSUM_W-1:0]                 o_psum
);

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves o_psum unassigned (no latch).
        o_psum = '0;
        for (int k = 0; k < FILTER_W; k++) begin
            if (i_spikes[k]) begin
                o_psum = o_psum + PSUM_W'(i_weights[k]);
            end
        end
    end

endmodule

// File: rtl/ppe_row_sync.sv
// Clocked partial-product element: loads a filter row, then emits one partial-sum packet per
// 1-D convolution window of each input spike row. Define PPE_SKIP_ZERO_EN to skip spike-free windows.
module ppe_row_sync
    import ppe_pkg::*;
#(
    parameter int PE_ID    = 5,
    parameter int SPE_ID   = 0,
    parameter int FILTER_W = 5,
    parameter int IFMAP_W  = 25,
    parameter int WEIGHT_W = 8,
    parameter int ADDR_W   = 4,
    parameter int OPCODE_W = 4,
    parameter int DATA_W   = 25
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ADDR_W+OPCODE_W+DATA_W-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ADDR_W+OPCODE_W+DATA_W-1:0] out_data,
    output logic                             weights_loaded,
    output logic                             err_drop
);

    localparam int WPP    = DATA_W / WEIGHT_W;
    localparam int OUT_W  = IFMAP_W - FILTER_W + 1;
    localparam int PSUM_W = WEIGHT_W + $clog2(FILTER_W);
    localparam int IDX_W  = $clog2(OUT_W);
    localparam int CNT_W  = $clog2(OUT_W + 1);
    localparam int PTR_W  = $clog2(FILTER_W + 1);

    state_t                            r_state, w_next_state;
    packet_t                           w_in_pkt, w_out_pkt;
    logic [FILTER_W-1:0][WEIGHT_W-1:0] r_w;
    logic [PTR_W-1:0]                  r_w_ptr, w_w_base, w_ptr_next;
    logic [PTR_W:0]                    w_ptr_sum;
    logic                              r_loaded;
    logic [IFMAP_W-1:0]                r_spikes;
    logic [CNT_W-1:0]                  r_j;
    logic [IDX_W-1:0]                  w_idx;
    logic [FILTER_W-1:0]               w_window;
    logic [PSUM_W-1:0]                 w_psum;
    logic                              r_in_ready, r_out_valid, r_err_drop;
    packet_t                           r_out_data;
    logic                              w_in_xfer, w_addr_ok, w_is_weight, w_is_input;
    logic                              w_advance, w_more, w_last, w_skip;

    assign w_in_pkt    = in_data;
    assign w_in_xfer   = in_valid && r_in_ready;
    assign w_addr_ok   = (w_in_pkt.addr == ADDR_W'(PE_ID));
    assign w_is_weight = w_addr_ok && (w_in_pkt.opcode == OPCODE_W'(OP_WEIGHT));
    assign w_is_input  = w_addr_ok && (w_in_pkt.opcode == OPCODE_W'(OP_INPUT)) && r_loaded;

    // A weight packet arriving with a full row held restarts the load from slot 0.
    assign w_w_base   = r_loaded ? '0 : r_w_ptr;
    assign w_ptr_sum  = {1'b0, w_w_base} + (PTR_W+1)'(WPP);
    assign w_ptr_next = (w_ptr_sum >= (PTR_W+1)'(FILTER_W)) ? PTR_W'(FILTER_W)
                                                            : w_ptr_sum[PTR_W-1:0];

    // r_j indexes the window to be loaded next; OUT_W means every window has been loaded.
    assign w_advance = (r_state == S_EMIT) && (!r_out_valid || out_ready);
    assign w_more    = (r_j < CNT_W'(OUT_W));
    assign w_last    = (r_j == CNT_W'(OUT_W - 1));
    assign w_idx     = w_more ? r_j[IDX_W-1:0] : '0;
    assign w_window  = r_spikes[w_idx +: FILTER_W];

`ifdef PPE_SKIP_ZERO_EN
    assign w_skip = ~|w_window;
`else
    assign w_skip = 1'b0;
`endif

    ppe_window_mac #(
        .FILTER_W (FILTER_W),
        .WEIGHT_W (WEIGHT_W),
        .PSUM_W   (PSUM_W)
    ) u_mac (
        .i_spikes  (w_window),
        .i_weights (r_w),
        .o_psum    (w_psum)
    );

    always_comb begin
        w_out_pkt                      = '0;
        w_out_pkt.addr                 = ADDR_W'(SPE_ID);
        w_out_pkt.opcode               = OP_PSUM;
        w_out_pkt.data[PSUM_W-1:0]     = w_psum;
        w_out_pkt.data[J_POS +: IDX_W] = w_idx;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_in_xfer && w_is_input) w_next_state = S_EMIT;
            S_EMIT: if (w_advance && (!w_more || (w_skip && w_last))) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the weight row is a handful of flops and must read as zero after reset, so it is reset too.
            r_w         <= '0;
            r_w_ptr     <= '0;
            r_loaded    <= 1'b0;
            r_spikes    <= '0;
            r_j         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err_drop  <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            r_in_ready <= (w_next_state == S_IDLE);
            r_err_drop <= w_in_xfer && !(w_is_weight || w_is_input);

            if (w_in_xfer && w_is_weight) begin
                for (int k = 0; k < FILTER_W; k++) begin
                    for (int i = 0; i < WPP; i++) begin
                        if (k >= i && w_w_base == PTR_W'(k - i)) begin
                            r_w[k] <= w_in_pkt.data[WEIGHT_W*i +: WEIGHT_W];
                        end
                    end
                end
                r_w_ptr  <= w_ptr_next;
                r_loaded <= (w_ptr_next == PTR_W'(FILTER_W));
            end

            if (w_in_xfer && w_is_input) begin
                r_spikes <= w_in_pkt.data[IFMAP_W-1:0];
                r_j      <= '0;
            end

            if (w_advance) begin
                if (w_more) begin
                    r_j         <= r_j + CNT_W'(1);
                    r_out_valid <= !w_skip;
                    if (!w_skip) begin
                        r_out_data <= w_out_pkt;
                    end
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign weights_loaded = r_loaded;
    assign err_drop       = r_err_drop;

endmodule

// File: tb/tb_ppe_row_sync.sv
// Self-checking bench for ppe_row_sync: scoreboard of expected partial-sum packets per row.
module tb_ppe_row_sync;

    localparam int OUT_W = 21;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, weights_loaded, err_drop;
    logic [32:0] in_data, out_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall_bad;
    logic [32:0] exp_q[$];
    logic [32:0] got[$];
    int unsigned tb_w[5] = '{1, 2, 3, 4, 5};

    localparam logic [24:0] ROW_ODD  = 25'h0AAAAAA;
    localparam logic [24:0] ROW_EVEN = 25'h1555555;

    always #5 clk = ~clk;

    ppe_row_sync dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .weights_loaded (weights_loaded),
        .err_drop       (err_drop)
    );

    function automatic logic [32:0] mk_pkt(input logic [3:0] a, input logic [3:0] op, input logic [24:0] d);
        return {a, op, d};
    endfunction

    function automatic logic [32:0] mk_out(input int j, input int psum);
        return {4'd0, 4'd2, 4'd0, 5'(j), 5'd0, 11'(psum)};
    endfunction

    function automatic int model_psum(input logic [24:0] s, input int j);
        int sum = 0;
        for (int k = 0; k < 5; k++) if (s[j+k]) sum += int'(tb_w[k]);
        return sum;
    endfunction

    task automatic push_row(input logic [24:0] s);
        logic [24:0] v;
        for (int j = 0; j < OUT_W; j++) begin
            v = s >> j;
`ifdef PPE_SKIP_ZERO_EN
            if (v[4:0] != 5'd0) exp_q.push_back(mk_out(j, model_psum(s, j)));
`else
            exp_q.push_back(mk_out(j, model_psum(s, j)));
`endif
        end
    endtask

    task automatic send(input logic [32:0] p, input string tag);
        int n = 0;
        @(negedge clk);
        in_data  = p;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 100) begin
            n_bad++;
            $display("FAIL %s_accept: in_ready got %b want 1 within 100 cycles", tag, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Collects every output transfer for a fixed number of cycles; optionally stalls once
    // for stall_len cycles when stall_at packets have been taken, noting any instability.
    task automatic capture(input int cycles, input int stall_at, input int stall_len);
        int          stall_left = stall_len;
        bit          stalling   = 1'b0;
        logic [32:0] held       = '0;
        got.delete();
        stall_bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && got.size() == stall_at && stall_left > 0) begin
                if (!stalling) begin
                    stalling = 1'b1;
                    held     = out_data;
                end else if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    stall_bad++;
                end
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 33'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (weights_loaded !== 1'b0) begin n_bad++; $display("FAIL reset_loaded: got %b want 0", weights_loaded); end
        n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_rise: got %b want 1", in_ready); end
    endtask

    task automatic test_drop_unloaded;
        send(mk_pkt(4'd5, 4'd1, ROW_ODD), "unloaded");
        n_cmp++; if (err_drop !== 1'b1) begin n_bad++; $display("FAIL unloaded_err_drop: got %b want 1", err_drop); end
        capture(30, -1, 0);
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL unloaded_outputs: got %0d want 0", got.size()); end
        n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL unloaded_pulse_end: got %b want 0", err_drop); end
    endtask

    task automatic test_weight_load;
        send(mk_pkt(4'd5, 4'd0, {1'b0, 8'd3, 8'd2, 8'd1}), "w0");
        n_cmp++; if (weights_loaded !== 1'b0) begin n_bad++; $display("FAIL wload_partial: got %b want 0", weights_loaded); end
        n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL wload_err0: got %b want 0", err_drop); end
        send(mk_pkt(4'd5, 4'd0, {1'b0, 8'd6, 8'd5, 8'd4}), "w1");
        n_cmp++; if (weights_loaded !== 1'b1) begin n_bad++; $display("FAIL wload_full: got %b want 1", weights_loaded); end
        n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL wload_err1: got %b want 0", err_drop); end
    endtask

    task automatic test_alternating;
        logic [24:0] rows[2] = '{ROW_ODD, ROW_EVEN};
        logic [32:0] e, a;
        for (int r = 0; r < 2; r++) begin
            send(mk_pkt(4'd5, 4'd1, rows[r]), "alt");
            for (int j = 0; j < OUT_W; j++) exp_q.push_back(mk_out(j, ((j + r) % 2 == 0) ? 6 : 9));
            capture(40, -1, 0);
            n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL alt_count: got %0d want %0d", got.size(), exp_q.size()); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = (got.size() > 0) ? got.pop_front() : 33'bx;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL alt_pkt: got %h want %h", a, e); end
            end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL alt_idle_ready: got %b want 1", in_ready); end
        end
    endtask

    task automatic test_backpressure;
        logic [32:0] e, a;
        send(mk_pkt(4'd5, 4'd1, ROW_ODD), "bp");
        push_row(ROW_ODD);
        capture(60, 7, 5);
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
        n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got.size() > 0) ? got.pop_front() : 33'bx;
            n_cmp++; if (a !== e) begin n_bad++; $display("FAIL bp_pkt: got %h want %h", a, e); end
        end
    endtask

    task automatic test_drops;
        send(mk_pkt(4'd3, 4'd0, {1'b0, 8'd9, 8'd9, 8'd9}), "addr3w");
        n_cmp++; if (err_drop !== 1'b1) begin n_bad++; $display("FAIL drop_addr_w: got %b want 1", err_drop); end
        n_cmp++; if (weights_loaded !== 1'b1) begin n_bad++; $display("FAIL drop_addr_loaded: got %b want 1", weights_loaded); end
        send(mk_pkt(4'd3, 4'd1, ROW_ODD), "addr3i");
        n_cmp++; if (err_drop !== 1'b1) begin n_bad++; $display("FAIL drop_addr_i: got %b want 1", err_drop); end
        capture(30, -1, 0);
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL drop_addr_outputs: got %0d want 0", got.size()); end
        send(mk_pkt(4'd5, 4'd7, 25'h1FFFFFF), "op7");
        n_cmp++; if (err_drop !== 1'b1) begin n_bad++; $display("FAIL drop_op7: got %b want 1", err_drop); end
        @(posedge clk);
        #1;
        n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL drop_pulse_width: got %b want 0", err_drop); end
    endtask

    task automatic test_skip_zero;
        logic [24:0] rows[2] = '{25'd0, 25'd1 << 12};
        logic [32:0] e, a;
        for (int r = 0; r < 2; r++) begin
            send(mk_pkt(4'd5, 4'd1, rows[r]), "skip");
            push_row(rows[r]);
            capture(40, -1, 0);
            n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL skip_count: got %0d want %0d", got.size(), exp_q.size()); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = (got.size() > 0) ? got.pop_front() : 33'bx;
                n_cmp++; if (a !== e) begin n_bad++; $display("FAIL skip_pkt: got %h want %h", a, e); end
            end
        end
    endtask

    task automatic test_reset_mid_row;
        bit found = 1'b0;
        send(mk_pkt(4'd5, 4'd1, ROW_EVEN), "mid");
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_data[20:16] == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_window10: got none want window 10 within 40 cycles"); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (weights_loaded !== 1'b0) begin n_bad++; $display("FAIL mid_loaded: got %b want 0", weights_loaded); end
        n_cmp++; if (out_data !== 33'd0) begin n_bad++; $display("FAIL mid_out_data: got %h want 0", out_data); end
        @(negedge clk);
        reset = 1'b0;
        send(mk_pkt(4'd5, 4'd1, ROW_EVEN), "post");
        n_cmp++; if (err_drop !== 1'b1) begin n_bad++; $display("FAIL mid_post_drop: got %b want 1", err_drop); end
        capture(30, -1, 0);
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL mid_post_outputs: got %0d want 0", got.size()); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_drop_unloaded();
        test_weight_load();
        test_alternating();
        test_backpressure();
        test_drops();
        test_skip_zero();
        test_reset_mid_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
